// File: rtl/vga_timing_pkg.sv
// Shared decoder types and default 1280x1024 timing.
// Used by vga_sync_decoder and its testbench.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } dec_state_t;

  localparam int DEF_H_SYNC  = 112;
  localparam int DEF_H_BACK  = 248;
  localparam int DEF_H_DISP  = 1280;
  localparam int DEF_H_FRONT = 48;
  localparam int DEF_V_SYNC  = 3;
  localparam int DEF_V_BACK  = 38;
  localparam int DEF_V_DISP  = 1024;
  localparam int DEF_V_FRONT = 1;

  function automatic int timing_limit(input int sync, input int back,
                                      input int disp, input int front);
    return sync + back + disp + front;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Two-stage sync register with polarity-aware leading-edge detect.
// lead is high for one cycle when the registered sync first reaches its active level.
module vga_sync_edge #(
  parameter bit POL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sync,
  output logic lead
);

  logic s_r;
  logic s_rr;

  // Resetting to the inactive level keeps lead quiet straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_r  <= ~POL;
      s_rr <= ~POL;
    end else begin
      s_r  <= sync;
      s_rr <= s_r;
    end
  end

  assign lead = (s_r == POL) && (s_rr != POL);

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from incoming hs/vs, verifies timing and reports lock.
// Define VGA_SYNC_DEC_MEASURE_EN to add the h_meas/v_meas measurement outputs.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int H_DISP      = DEF_H_DISP,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int V_DISP      = DEF_V_DISP,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter bit H_POL       = 1'b0,
  parameter bit V_POL       = 1'b0,
  parameter int LOCK_FRAMES = 2,
  localparam int H_LIMIT    = timing_limit(H_SYNC, H_BACK, H_DISP, H_FRONT),
  localparam int V_LIMIT    = timing_limit(V_SYNC, V_BACK, V_DISP, V_FRONT),
  localparam int XW         = $clog2(H_DISP),
  localparam int YW         = $clog2(V_DISP),
  localparam int XCW        = $clog2(H_LIMIT + 1),
  localparam int YCW        = $clog2(V_LIMIT + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           vga_hs,
  input  logic           vga_vs,
  output logic           disp,
  output logic [XW-1:0]  x_pos,
  output logic [YW-1:0]  y_pos,
  output logic           locked,
  output logic           frame_start,
  output logic           sync_err
`ifdef VGA_SYNC_DEC_MEASURE_EN
  ,
  output logic [XCW-1:0] h_meas,
  output logic [YCW-1:0] v_meas
`endif
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);

  localparam logic [XCW-1:0] H_MAX  = XCW'(H_LIMIT);
  localparam logic [XCW-1:0] H_LAST = XCW'(H_LIMIT - 1);
  localparam logic [XCW-1:0] H_ACT0 = XCW'(H_SYNC + H_BACK);
  localparam logic [XCW-1:0] H_ACT1 = XCW'(H_SYNC + H_BACK + H_DISP);
  localparam logic [YCW-1:0] V_MAX  = YCW'(V_LIMIT);
  localparam logic [YCW-1:0] V_LAST = YCW'(V_LIMIT - 1);
  localparam logic [YCW-1:0] V_ACT0 = YCW'(V_SYNC + V_BACK);
  localparam logic [YCW-1:0] V_ACT1 = YCW'(V_SYNC + V_BACK + V_DISP);
  localparam logic [GW-1:0]  GOOD_LAST = GW'(LOCK_FRAMES - 1);

  localparam bit [1:0] SYNC_POL = {V_POL, H_POL};

  logic [1:0]     sync_pins;
  logic [1:0]     leads;
  logic           lead_h;
  logic           lead_v;
  logic [XCW-1:0] x_cnt_reg;
  logic [YCW-1:0] y_cnt_reg;
  logic [GW-1:0]  good_cnt_reg;
  logic           frame_bad_reg;
  logic           h_armed_reg;
  logic           locked_reg;
  logic           sync_err_reg;
  dec_state_t     state_reg;
  logic           line_bad;
  logic           line_bad_chk;
  logic           frame_ok;
  logic           frame_fail;

  assign sync_pins = {vga_vs, vga_hs};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_edge
      vga_sync_edge #(
        .POL(SYNC_POL[gi])
      ) u_edge (
        .clk  (clk),
        .reset(reset),
        .sync (sync_pins[gi]),
        .lead (leads[gi])
      );
    end
  endgenerate

  assign lead_h = leads[0];
  assign lead_v = leads[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      x_cnt_reg <= '0;
      y_cnt_reg <= '0;
    end else begin
      if (lead_h)
        x_cnt_reg <= '0;
      else if (x_cnt_reg != H_MAX)
        x_cnt_reg <= x_cnt_reg + XCW'(1);
      if (lead_v)
        y_cnt_reg <= '0;
      else if (lead_h && y_cnt_reg != V_MAX)
        y_cnt_reg <= y_cnt_reg + YCW'(1);
    end
  end

  // A stuck hs shows up as x_cnt pinned at its saturation value.
  assign line_bad     = (lead_h && x_cnt_reg != H_LAST) || (x_cnt_reg == H_MAX);
  assign line_bad_chk = line_bad && h_armed_reg;
  assign frame_ok     = (y_cnt_reg == V_LAST);
  assign frame_fail   = frame_bad_reg || line_bad_chk || !frame_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_SEARCH;
      good_cnt_reg  <= '0;
      frame_bad_reg <= 1'b0;
      h_armed_reg   <= 1'b0;
      locked_reg    <= 1'b0;
      sync_err_reg  <= 1'b0;
    end else begin
      sync_err_reg <= 1'b0;
      case (state_reg)
        ST_SEARCH: begin
          if (lead_v) begin
            state_reg     <= ST_TRACK;
            good_cnt_reg  <= '0;
            frame_bad_reg <= 1'b0;
            h_armed_reg   <= 1'b0;
          end
        end
        ST_TRACK: begin
          if (lead_h)
            h_armed_reg <= 1'b1;
          if (lead_v) begin
            frame_bad_reg <= 1'b0;
            if (frame_fail) begin
              good_cnt_reg <= '0;
            end else if (good_cnt_reg == GOOD_LAST) begin
              good_cnt_reg <= '0;
              state_reg    <= ST_LOCKED;
              locked_reg   <= 1'b1;
            end else begin
              good_cnt_reg <= good_cnt_reg + GW'(1);
            end
          end else if (line_bad_chk) begin
            frame_bad_reg <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (line_bad_chk || (lead_v && !frame_ok)) begin
            state_reg    <= ST_SEARCH;
            locked_reg   <= 1'b0;
            sync_err_reg <= 1'b1;
          end
        end
        default: begin
          state_reg  <= ST_SEARCH;
          locked_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_SYNC_DEC_MEASURE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      h_meas <= '0;
      v_meas <= '0;
    end else begin
      if (lead_h)
        h_meas <= (x_cnt_reg == H_MAX) ? H_MAX : x_cnt_reg + XCW'(1);
      if (lead_v)
        v_meas <= (y_cnt_reg == V_MAX) ? V_MAX : y_cnt_reg + YCW'(1);
    end
  end
`endif

  assign disp = locked_reg
             && (x_cnt_reg >= H_ACT0) && (x_cnt_reg < H_ACT1)
             && (y_cnt_reg >= V_ACT0) && (y_cnt_reg < V_ACT1);

  // Coordinates are forced to zero outside the active region so reset leaves every output at 0.
  assign x_pos = disp ? XW'(x_cnt_reg - H_ACT0) : '0;
  assign y_pos = disp ? YW'(y_cnt_reg - V_ACT0) : '0;

  assign locked      = locked_reg;
  assign sync_err    = sync_err_reg;
  assign frame_start = lead_v;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder with small timing (28 clocks x 13 lines).
// A second instance with active-high polarity sees the inverted syncs.
module tb_vga_sync_decoder;
  import vga_timing_pkg::*;

  logic       clk;
  logic       reset;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_hs_p;
  logic       vga_vs_p;
  logic       disp,   disp_p;
  logic [3:0] x_pos,  x_pos_p;
  logic [2:0] y_pos,  y_pos_p;
  logic       locked, locked_p;
  logic       frame_start, frame_start_p;
  logic       sync_err, sync_err_p;
`ifdef VGA_SYNC_DEC_MEASURE_EN
  logic [4:0] h_meas, h_meas_p;
  logic [3:0] v_meas, v_meas_p;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_err, n_err_p, err_cyc, n_fs, fs_last, lock_cyc, lock_cyc_p;
  int disp_tot, disp_tot_p, pos_bad, exp_x, exp_y, mark;
  logic prev_locked = 1'b0;
  logic prev_locked_p = 1'b0;
  logic locked_at_err;

  assign vga_hs_p = ~vga_hs;
  assign vga_vs_p = ~vga_vs;

  vga_sync_decoder #(
    .H_SYNC(4), .H_BACK(4), .H_DISP(16), .H_FRONT(4),
    .V_SYNC(2), .V_BACK(2), .V_DISP(8), .V_FRONT(1),
    .H_POL(1'b0), .V_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .disp(disp), .x_pos(x_pos), .y_pos(y_pos), .locked(locked),
    .frame_start(frame_start), .sync_err(sync_err)
`ifdef VGA_SYNC_DEC_MEASURE_EN
    , .h_meas(h_meas), .v_meas(v_meas)
`endif
  );

  vga_sync_decoder #(
    .H_SYNC(4), .H_BACK(4), .H_DISP(16), .H_FRONT(4),
    .V_SYNC(2), .V_BACK(2), .V_DISP(8), .V_FRONT(1),
    .H_POL(1'b1), .V_POL(1'b1), .LOCK_FRAMES(2)
  ) dut_p (
    .clk(clk), .reset(reset), .vga_hs(vga_hs_p), .vga_vs(vga_vs_p),
    .disp(disp_p), .x_pos(x_pos_p), .y_pos(y_pos_p), .locked(locked_p),
    .frame_start(frame_start_p), .sync_err(sync_err_p)
`ifdef VGA_SYNC_DEC_MEASURE_EN
    , .h_meas(h_meas_p), .v_meas(v_meas_p)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_err = 0; n_err_p = 0; err_cyc = -1; n_fs = 0; fs_last = -1;
    lock_cyc = -1; lock_cyc_p = -1; disp_tot = 0; disp_tot_p = 0; pos_bad = 0;
    locked_at_err = 1'bx;
  endtask

  // One pixel clock: drive pins (active-low for dut), then observe just after the edge.
  task automatic step(input logic hs_act, input logic vs_act);
    vga_hs = ~hs_act;
    vga_vs = ~vs_act;
    @(posedge clk);
    #1;
    cyc++;
    if (sync_err) begin n_err++; err_cyc = cyc; locked_at_err = locked; end
    if (sync_err_p) n_err_p++;
    if (frame_start) begin n_fs++; fs_last = cyc; exp_x = 0; exp_y = 0; end
    if (locked && !prev_locked) lock_cyc = cyc;
    if (locked_p && !prev_locked_p) lock_cyc_p = cyc;
    prev_locked = locked;
    prev_locked_p = locked_p;
    if (disp_p) disp_tot_p++;
    if (disp) begin
      disp_tot++;
      if (x_pos !== exp_x[3:0] || y_pos !== exp_y[2:0]) pos_bad++;
      exp_x++;
      if (exp_x == 16) begin exp_x = 0; exp_y++; end
    end
  endtask

  task automatic line_seg(input int from, input int to, input logic vs_act, input bit hs_en);
    for (int i = from; i < to; i++) step(hs_en && (i < 4), vs_act);
  endtask

  task automatic line(input int len, input logic vs_act);
    line_seg(0, len, vs_act, 1'b1);
  endtask

  task automatic frame(input int nlines);
    for (int l = 0; l < nlines; l++) line(28, l < 2);
  endtask

  initial begin
    reset = 1'b1;
    vga_hs = 1'b1;
    vga_vs = 1'b1;
    clr();
    exp_x = 0;
    exp_y = 0;
    repeat (3) step(1'b0, 1'b0);
    check("rst_locked", locked, 0);
    check("rst_disp", disp, 0);
    check("rst_sync_err", sync_err, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_x_pos", x_pos, 0);
    check("rst_y_pos", y_pos, 0);
    check("rst_state", dut.state_reg, ST_SEARCH);
    check("rst_locked_p", locked_p, 0);
    check("rst_pos_p", {x_pos_p, y_pos_p}, 0);
    reset = 1'b0;
    repeat (5) step(1'b0, 1'b0);
    $display("reset: total=%0d", total);

    // Nominal stream; both polarities lock one cycle after the third frame start.
    clr();
    frame(13);
    frame(13);
    check("s1_unlocked_after_f2", locked, 0);
    frame(13);
    check("s1_frame_starts", n_fs, 3);
    check("s1_lock_cycle", lock_cyc, fs_last + 1);
    check("s5_lock_cycle_pol", lock_cyc_p, fs_last + 1);
    clr();
    frame(13);
    check("s1_disp_count", disp_tot, 128);
    check("s5_disp_count_pol", disp_tot_p, 128);
    check("s1_pos_seq_errors", pos_bad, 0);
    check("s1_no_sync_err", n_err, 0);
    check("s1_still_locked", locked, 1);
    $display("scenario 1/5 nominal lock: total=%0d", total);

    // Line 5 shortened to 27 clocks.
    clr();
    for (int l = 0; l < 13; l++) begin
      if (l == 6) begin mark = cyc + 1; disp_tot = 0; end
      line((l == 5) ? 27 : 28, l < 2);
    end
    check("s2_err_pulses", n_err, 1);
    check("s2_err_cycle", err_cyc, mark + 1);
    check("s2_locked_at_err", locked_at_err, 0);
    check("s2_disp_after_err", disp_tot, 0);
    check("s2_err_pulses_pol", n_err_p, 1);
    check("s2_locked_after", locked, 0);
    $display("scenario 2 short line: total=%0d", total);

    // 12-line frame during TRACK restarts the good-frame count.
    clr();
    frame(13);
    frame(12);
    frame(13);
    frame(13);
    check("s4_no_early_lock", locked, 0);
    frame(13);
    check("s4_lock_cycle", lock_cyc, fs_last + 1);
    check("s4_lock_cycle_pol", lock_cyc_p, fs_last + 1);
    $display("scenario 4 short frame: total=%0d", total);

    // hs stuck inactive while locked.
    clr();
    mark = cyc + 1;
    repeat (40) step(1'b0, 1'b0);
    check("s3_err_pulses", n_err, 1);
    check("s3_err_cycle", err_cyc, mark + 2);
    check("s3_locked_after", locked, 0);
    check("s3_no_frame_start", n_fs, 0);
    $display("scenario 3 stuck hs: total=%0d", total);

    // Relock, then reset in the middle of an active line.
    clr();
    frame(13);
    frame(13);
    frame(13);
    check("s6_relock_cycle", lock_cyc, fs_last + 1);
    for (int l = 0; l < 6; l++) line(28, l < 2);
    line_seg(0, 15, 1'b0, 1'b1);
    check("s6_disp_before_reset", disp, 1);
    reset = 1'b1;
    line_seg(15, 16, 1'b0, 1'b1);
    reset = 1'b0;
    check("s6_locked", locked, 0);
    check("s6_disp", disp, 0);
    check("s6_sync_err", sync_err, 0);
    check("s6_frame_start", frame_start, 0);
    check("s6_x_pos", x_pos, 0);
    check("s6_y_pos", y_pos, 0);
    check("s6_state", dut.state_reg, ST_SEARCH);
    check("s6_locked_p", locked_p, 0);
    clr();
    line_seg(16, 28, 1'b0, 1'b1);
    for (int l = 7; l < 13; l++) line(28, 1'b0);
    frame(13);
    frame(13);
    check("s6_no_early_relock", locked, 0);
    frame(13);
    check("s6_relock_after_reset", lock_cyc, fs_last + 1);
    check("s6_relock_after_reset_pol", lock_cyc_p, fs_last + 1);
    check("s6_no_sync_err", n_err, 0);
    $display("scenario 6 reset mid-frame: total=%0d", total);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
